board_io_ctrl: RTL and testbench
================================

Name: board_io_ctrl

Overview:
- Parametrised board-level I/O controller sitting between the FPGA top and the core.
- Debounces and edge-detects N switches and drives M plain LEDs (off/on/blink/mirror-switch).
- Drives K RGB LEDs with per-colour PWM duty, configured through a simple write port.
- Replaces ad-hoc tie-offs and free-running divider logic in board tops.

Parameters:
- NUM_SW, 2, number of switch inputs (1..16)
- NUM_LED, 4, number of plain LEDs (1..16)
- NUM_RGB, 4, number of RGB LEDs (1..16)
- PWM_W, 8, PWM duty/counter width
- PWM_PRESC, 4, clk cycles per PWM counter step (>=1)
- DEB_CYCLES, 16, stable cycles required before a switch change is accepted (>=1)
- BLINK_BIT, 22, free-running counter bit used as blink source (< 32)
- ADDR_W, 6, config address width; top 2 bits select bank, low ADDR_W-2 bits index

Ports:
- clk, in, 1, single clock
- reset, in, 1, asynchronous, active-low reset
- sw_in, in, NUM_SW, raw asynchronous switch pins
- sw_out, out, NUM_SW, debounced switch level
- sw_rise, out, NUM_SW, 1-cycle pulse on debounced 0->1
- sw_fall, out, NUM_SW, 1-cycle pulse on debounced 1->0
- cfg_we, in, 1, config write strobe, single-cycle, always accepted
- cfg_addr, in, ADDR_W, config address
- cfg_wdata, in, PWM_W, config write data
- led, out, NUM_LED, plain LED drive
- led_r, out, NUM_RGB, red PWM output
- led_g, out, NUM_RGB, green PWM output
- led_b, out, NUM_RGB, blue PWM output

Behaviour:
- Reset (asserted low, async): sw_out/sw_rise/sw_fall=0; all duties=0; LED0 mode=BLINK, other LED modes=OFF; all counters=0; led/led_r/led_g/led_b=0. All outputs are registered.
- Debounce per switch: 2-flop synchroniser, then a counter. When the synchronised value differs from sw_out, the counter increments; if it matches, the counter clears.
- Debounce commit: when the counter reaches DEB_CYCLES, sw_out takes the new value, the counter clears and the matching rise/fall pulse asserts in the same cycle. Latency from a clean pin edge is 2+DEB_CYCLES cycles; a glitch shorter than DEB_CYCLES never propagates.
- Config decode, bank = cfg_addr[ADDR_W-1:ADDR_W-2], idx = low bits:
  - bank 0: LED mode, cfg_wdata[1:0] (0 OFF, 1 ON, 2 BLINK, 3 MIRROR)
  - bank 1: red duty; bank 2: green duty; bank 3: blue duty
  - Writes with idx >= channel count of the bank are silently dropped.
  - Mode writes take effect on the next cycle's led output.
- LED modes: OFF=0; ON=1; BLINK=blink_cnt[BLINK_BIT] (32-bit free-running, wraps); MIRROR=sw_out[idx % NUM_SW].
- PWM step and shadowing: prescaler counts 0..PWM_PRESC-1; pwm_cnt (PWM_W bits) increments on prescaler terminal count and wraps 2^PWM_W-1 -> 0. Duty writes land in a shadow register and are copied to the active register only when pwm_cnt wraps to 0, so there are no glitched periods.
- PWM output: out = (active_duty > pwm_cnt), registered.
  - duty 0 gives constant 0.
  - duty 2^PWM_W-1 is high for (2^PWM_W-1)/2^PWM_W of the period.
- Simultaneous events: a write to a shadow in the copy cycle is lost to the old copy and applies at the next wrap. Multiple writes within one period keep only the last.
- Reset mid-period: all state clears immediately; PWM restarts at pwm_cnt=0 with duty 0.

Optional Feature:
- Macro: BOARD_IO_GAMMA_EN.
- Defined: the active duty is gamma-corrected, eff = (duty*duty) >> PWM_W, using a 2*PWM_W-bit product computed at shadow copy. This adds no output latency.
- Undefined: eff = duty, and no multiplier is instantiated.

Decomposition:
- Package board_io_pkg:
  - led_mode_t enum (OFF, ON, BLINK, MIRROR)
  - bank_t encoding constants (BANK_MODE=0, BANK_R=1, BANK_G=2, BANK_B=3)
- Sub-module sw_debounce (parameter DEB_CYCLES): single-switch synchroniser, debounce counter and edge pulses; instantiated NUM_SW times via generate.

Test Plan:
- Clean press, DEB_CYCLES=16: sw_in[0] 0->1 held -> sw_out[0]=1 and sw_rise[0] pulse exactly 18 cycles later; release gives a sw_fall[0] pulse after 18 cycles.
- Bounce: sw_in[1] toggles every 5 cycles for 100 cycles, then settles at 1 -> no pulses during the bounce; one sw_rise 18 cycles after settling.
- PWM, PWM_W=8, PWM_PRESC=1: write bank1 idx2 duty 64 -> led_r[2] high 64 of every 256 cycles, starting at the first pwm_cnt wrap. Duty 0 gives constant low; duty 255 is high 255/256.
- Mid-period duty change: duty 200 written at pwm_cnt=50 while active=64 -> the current period stays 64 high, the next period is 200 high; with BOARD_IO_GAMMA_EN, 200 gives 156 high.
- LED modes: after reset led[0] follows blink_cnt[BLINK_BIT] (use BLINK_BIT=3 in sim). Write mode 3 to idx1 -> led[1] tracks sw_out[1]. Write to idx 7 with NUM_LED=4 -> no state change.
- Async reset asserted mid-PWM-high and mid-debounce -> all outputs 0 in the same cycle; LED0 back to BLINK; pending shadow duties discarded.

Source files
------------

// File: rtl/board_io_pkg.sv
// rtl/board_io_pkg.sv - shared types and config bank encodings for board_io_ctrl
package board_io_pkg;

  typedef enum logic [1:0] {
    LED_OFF    = 2'd0,
    LED_ON     = 2'd1,
    LED_BLINK  = 2'd2,
    LED_MIRROR = 2'd3
  } led_mode_t;

  typedef logic [1:0] bank_t;

  localparam bank_t BANK_MODE = 2'd0;
  localparam bank_t BANK_R    = 2'd1;
  localparam bank_t BANK_G    = 2'd2;
  localparam bank_t BANK_B    = 2'd3;

endpackage

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - single-switch synchroniser, debounce counter and edge pulses
module sw_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_in,
  output logic sw_out,
  output logic sw_rise,
  output logic sw_fall
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      cnt     <= '0;
      sw_out  <= 1'b0;
      sw_rise <= 1'b0;
      sw_fall <= 1'b0;
    end else begin
      sync1   <= sw_in;
      sync2   <= sync1;
      sw_rise <= 1'b0;
      sw_fall <= 1'b0;
      if (sync2 != sw_out) begin
        // Commit on the DEB_CYCLES-th consecutive mismatching sample.
        if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
          sw_out  <= sync2;
          cnt     <= '0;
          sw_rise <= sync2;
          sw_fall <= ~sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/board_io_ctrl.sv
// rtl/board_io_ctrl.sv - switch debounce, plain LED modes and shadowed RGB PWM
// Optional gamma correction of active duty when BOARD_IO_GAMMA_EN is defined.
module board_io_ctrl
  import board_io_pkg::*;
#(
  parameter int NUM_SW     = 2,
  parameter int NUM_LED    = 4,
  parameter int NUM_RGB    = 4,
  parameter int PWM_W      = 8,
  parameter int PWM_PRESC  = 4,
  parameter int DEB_CYCLES = 16,
  parameter int BLINK_BIT  = 22,
  parameter int ADDR_W     = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_SW-1:0] sw_in,
  output logic [NUM_SW-1:0] sw_out,
  output logic [NUM_SW-1:0] sw_rise,
  output logic [NUM_SW-1:0] sw_fall,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [PWM_W-1:0]  cfg_wdata,
  output logic [NUM_LED-1:0] led,
  output logic [NUM_RGB-1:0] led_r,
  output logic [NUM_RGB-1:0] led_g,
  output logic [NUM_RGB-1:0] led_b
);

  localparam int IDX_W   = ADDR_W - 2;
  localparam int PRESC_W = (PWM_PRESC > 1) ? $clog2(PWM_PRESC) : 1;

  bank_t             bank;
  logic [IDX_W-1:0]  idx;
  assign bank = cfg_addr[ADDR_W-1 -: 2];
  assign idx  = cfg_addr[IDX_W-1:0];

  for (genvar g = 0; g < NUM_SW; g++) begin : g_sw
    sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk     (clk),
      .reset   (reset),
      .sw_in   (sw_in[g]),
      .sw_out  (sw_out[g]),
      .sw_rise (sw_rise[g]),
      .sw_fall (sw_fall[g])
    );
  end

  // Only the bits up to BLINK_BIT are observable, so the wider counter is not kept.
  logic [BLINK_BIT:0] blink_cnt;
  led_mode_t          mode [NUM_LED];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_cnt <= '0;
      led       <= '0;
      for (int i = 0; i < NUM_LED; i++) mode[i] <= (i == 0) ? LED_BLINK : LED_OFF;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
      for (int i = 0; i < NUM_LED; i++) begin
        if (cfg_we && bank == BANK_MODE && idx == IDX_W'(i))
          mode[i] <= led_mode_t'(cfg_wdata[1:0]);
        case (mode[i])
          LED_OFF:    led[i] <= 1'b0;
          LED_ON:     led[i] <= 1'b1;
          LED_BLINK:  led[i] <= blink_cnt[BLINK_BIT];
          LED_MIRROR: led[i] <= sw_out[i % NUM_SW];
          default:    led[i] <= 1'b0;
        endcase
      end
    end
  end

  function automatic logic [PWM_W-1:0] eff_duty(input logic [PWM_W-1:0] d);
`ifdef BOARD_IO_GAMMA_EN
    return PWM_W'(((2 * PWM_W)'(d) * (2 * PWM_W)'(d)) >> PWM_W);
`else
    return d;
`endif
  endfunction

  logic [PRESC_W-1:0] presc;
  logic [PWM_W-1:0]   pwm_cnt;
  logic [PWM_W-1:0]   shadow [3][NUM_RGB];
  logic [PWM_W-1:0]   active [3][NUM_RGB];
  logic               presc_tc;
  logic               wrap;

  assign presc_tc = (presc == PRESC_W'(PWM_PRESC - 1));
  assign wrap     = presc_tc && (pwm_cnt == '1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc   <= '0;
      pwm_cnt <= '0;
      led_r   <= '0;
      led_g   <= '0;
      led_b   <= '0;
      for (int c = 0; c < 3; c++)
        for (int i = 0; i < NUM_RGB; i++) begin
          shadow[c][i] <= '0;
          active[c][i] <= '0;
        end
    end else begin
      if (presc_tc) begin
        presc   <= '0;
        pwm_cnt <= pwm_cnt + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
      // A write landing on the copy edge is seen only at the following wrap.
      for (int c = 0; c < 3; c++)
        for (int i = 0; i < NUM_RGB; i++) begin
          if (wrap) active[c][i] <= eff_duty(shadow[c][i]);
          if (cfg_we && bank == bank_t'(c + 1) && idx == IDX_W'(i))
            shadow[c][i] <= cfg_wdata;
        end
      for (int i = 0; i < NUM_RGB; i++) begin
        led_r[i] <= active[0][i] > pwm_cnt;
        led_g[i] <= active[1][i] > pwm_cnt;
        led_b[i] <= active[2][i] > pwm_cnt;
      end
    end
  end

endmodule

// File: tb/tb_board_io_ctrl.sv
// tb/tb_board_io_ctrl.sv - directed self-checking bench for board_io_ctrl
module tb_board_io_ctrl;

  localparam int NUM_SW = 2, NUM_LED = 4, NUM_RGB = 4, PWM_W = 8;
  localparam int PWM_PRESC = 1, DEB_CYCLES = 16, BLINK_BIT = 3, ADDR_W = 6;
  localparam int PERIOD = 256;
  localparam int LAT = 2 + DEB_CYCLES;

  logic               clk;
  logic               reset;
  logic [NUM_SW-1:0]  sw_in, sw_out, sw_rise, sw_fall;
  logic               cfg_we;
  logic [ADDR_W-1:0]  cfg_addr;
  logic [PWM_W-1:0]   cfg_wdata;
  logic [NUM_LED-1:0] led;
  logic [NUM_RGB-1:0] led_r, led_g, led_b;

  int checks = 0;
  int errors = 0;
  int cyc;

  board_io_ctrl #(
    .NUM_SW(NUM_SW), .NUM_LED(NUM_LED), .NUM_RGB(NUM_RGB), .PWM_W(PWM_W),
    .PWM_PRESC(PWM_PRESC), .DEB_CYCLES(DEB_CYCLES), .BLINK_BIT(BLINK_BIT), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset), .sw_in(sw_in), .sw_out(sw_out), .sw_rise(sw_rise),
    .sw_fall(sw_fall), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .led(led), .led_r(led_r), .led_g(led_g), .led_b(led_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising edges since reset release; with PWM_PRESC=1, pwm_cnt == cyc % 256.
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int eff(input int d);
`ifdef BOARD_IO_GAMMA_EN
    return (d * d) >> PWM_W;
`else
    return d;
`endif
  endfunction

  task automatic cfg_wr(input logic [1:0] b, input logic [3:0] ix, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = {b, ix}; cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic goto_phase(input int p);
    for (int n = 0; n < 2 * PERIOD && (cyc % PERIOD) != p; n++) @(negedge clk);
  endtask

  task automatic wait_sw(input int b, input logic lvl, output int n);
    n = 1;
    @(negedge clk);
    while (sw_out[b] !== lvl && n <= 3 * LAT) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Counts led_r[2] / led_g[0] high cycles over one period starting at phase 1.
  task automatic measure(input int wr_at, input logic [1:0] b, input logic [3:0] ix,
                         input logic [7:0] d, output int hr, output int hg);
    hr = 0; hg = 0;
    for (int i = 0; i < PERIOD; i++) begin
      hr += int'(led_r[2]);
      hg += int'(led_g[0]);
      cfg_we = (i == wr_at); cfg_addr = {b, ix}; cfg_wdata = d;
      @(negedge clk);
    end
    cfg_we = 1'b0;
  endtask

  initial begin
    int n, hr, hg, pulses, first_rise;
    reset = 1'b0; sw_in = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    repeat (3) @(negedge clk);
    check("reset_sw_out", sw_out, 0);
    check("reset_led", led, 0);
    check("reset_rgb", {led_r, led_g, led_b}, 0);
    reset = 1'b1;

    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("blink_led0", led[0], ((cyc - 1) >> BLINK_BIT) & 1);
    end
    check("leds_off", led[3:1], 0);

    sw_in[0] = 1'b1;
    wait_sw(0, 1'b1, n);
    check("press_latency", n, LAT);
    check("press_rise", sw_rise[0], 1);
    @(negedge clk);
    check("rise_one_cycle", sw_rise[0], 0);
    sw_in[0] = 1'b0;
    wait_sw(0, 1'b0, n);
    check("release_latency", n, LAT);
    check("release_fall", sw_fall[0], 1);

    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      sw_in[1] = (i % 2 == 0);
      repeat (5) begin
        @(negedge clk);
        pulses += int'(sw_rise[1]) + int'(sw_fall[1]);
      end
    end
    check("bounce_pulses", pulses, 0);
    check("bounce_level", sw_out[1], 0);
    sw_in[1] = 1'b1;
    wait_sw(1, 1'b1, n);
    check("settle_latency", n, LAT);
    check("settle_rise", sw_rise[1], 1);

    cfg_wr(BANK_MODE_C(), 4'd1, 8'd3);
    @(negedge clk);
    check("mirror_high", led[1], 1);
    cfg_wr(BANK_MODE_C(), 4'd2, 8'd1);
    @(negedge clk);
    check("mode_on", led[2], 1);
    cfg_wr(BANK_MODE_C(), 4'd7, 8'd1);
    @(negedge clk);
    check("idx7_dropped", led[3], 0);
    sw_in[1] = 1'b0;
    wait_sw(1, 1'b0, n);
    check("sw1_release", n, LAT);
    @(negedge clk);
    check("mirror_low", led[1], 0);

    goto_phase(10);
    cfg_wr(2'd1, 4'd2, 8'd64);
    cfg_wr(2'd1, 4'd6, 8'd255);
    goto_phase(1);
    measure(-1, 2'd0, 4'd0, 8'd0, hr, hg);
    check("duty64", hr, eff(64));
    check("green_idle", hg, 0);
    measure(49, 2'd1, 4'd2, 8'd200, hr, hg);
    check("midchange_old", hr, eff(64));
    measure(-1, 2'd0, 4'd0, 8'd0, hr, hg);
    check("midchange_new", hr, eff(200));
    goto_phase(100);
    cfg_wr(2'd1, 4'd2, 8'd255);
    goto_phase(1);
    measure(-1, 2'd0, 4'd0, 8'd0, hr, hg);
    check("duty255", hr, eff(255));
    goto_phase(100);
    cfg_wr(2'd1, 4'd2, 8'd100);
    cfg_wr(2'd1, 4'd2, 8'd30);
    goto_phase(1);
    measure(-1, 2'd0, 4'd0, 8'd0, hr, hg);
    check("last_write_wins", hr, eff(30));
    measure(254, 2'd1, 4'd2, 8'd77, hr, hg);
    check("copy_edge_cur", hr, eff(30));
    measure(-1, 2'd0, 4'd0, 8'd0, hr, hg);
    check("copy_edge_lost", hr, eff(30));
    measure(-1, 2'd0, 4'd0, 8'd0, hr, hg);
    check("copy_edge_next", hr, eff(77));
    goto_phase(100);
    cfg_wr(2'd1, 4'd2, 8'd0);
    goto_phase(1);
    measure(-1, 2'd0, 4'd0, 8'd0, hr, hg);
    check("duty0", hr, 0);

    goto_phase(100);
    cfg_wr(2'd1, 4'd2, 8'd200);
    cfg_wr(2'd2, 4'd0, 8'd128);
    goto_phase(15);
    sw_in[0] = 1'b1;
    repeat (6) @(negedge clk);
    check("pre_reset_r_high", led_r[2], 1);
    cfg_wr(2'd2, 4'd0, 8'd50);
    #2 reset = 1'b0;
    #1;
    check("async_sw_out", sw_out, 0);
    check("async_led", led, 0);
    check("async_rgb", {led_r, led_g, led_b}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    first_rise = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      check("blink_after_reset", led[0], ((cyc - 1) >> BLINK_BIT) & 1);
      if (first_rise == 0 && sw_out[0]) first_rise = i;
    end
    check("deb_after_reset", first_rise, LAT);
    check("modes_after_reset", led[3:1], 0);
    goto_phase(1);
    measure(-1, 2'd0, 4'd0, 8'd0, hr, hg);
    check("red_cleared", hr, 0);
    check("green_discarded", hg, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  function automatic logic [1:0] BANK_MODE_C();
    return 2'd0;
  endfunction

endmodule
